// File: rtl/mdu_seq_if.sv
// mdu_seq_if: E-stage command and HI/LO result bundle between the pipeline
// (master) and the multiply/divide sequencer (slave).
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcAE;
    logic [WIDTH-1:0] srcBE;
    logic             mthiE;
    logic             mtloE;
    logic             mfhiE;
    logic             mfloE;
    logic [WIDTH-1:0] hiOut;
    logic [WIDTH-1:0] loOut;
    logic             busy;
    logic             mduStallE;

    modport master (
        output startE, opE, srcAE, srcBE, mthiE, mtloE, mfhiE, mfloE,
        input  hiOut, loOut, busy, mduStallE
    );

    modport slave (
        input  startE, opE, srcAE, srcBE, mthiE, mtloE, mfhiE, mfloE,
        output hiOut, loOut, busy, mduStallE
    );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MIPS32 MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Operates on operand magnitudes (shift-add multiply, restoring divide) and
// applies the sign fix-up in a final FIX cycle.
// Optional build macro MDU_EARLY_OUT_EN: multiply finishes as soon as the
// remaining multiplier bits are all zero.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_seq_if.slave    mdu
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_prod;     // running product magnitude
    logic [2*WIDTH-1:0] r_mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]   r_mplier;   // multiplier, consumed LSB first
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_quo;      // dividend bits in, quotient bits out
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_srcA;     // original rs, needed for divide-by-zero HI
    logic               r_signA;
    logic               r_signB;
    logic               r_div;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand magnitudes at start: only signed ops take the absolute value
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    assign w_signed = ~mdu.opE[0];
    assign w_sa     = w_signed & mdu.srcAE[WIDTH-1];
    assign w_sb     = w_signed & mdu.srcBE[WIDTH-1];
    assign w_magA   = w_sa ? (-mdu.srcAE) : mdu.srcAE;
    assign w_magB   = w_sb ? (-mdu.srcBE) : mdu.srcBE;

    // One shift-add multiply step
    logic [2*WIDTH-1:0] w_prod_step;
    logic [WIDTH-1:0]   w_mplier_nxt;
    assign w_prod_step  = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_mplier_nxt = r_mplier >> 1;

    // One restoring divide step; remainder after subtract always fits WIDTH bits
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_divisor;

    logic               w_last;
    logic               w_mul_done;
    assign w_last = (r_count == CW'(WIDTH - 1));
`ifdef MDU_EARLY_OUT_EN
    assign w_mul_done = w_last | (w_mplier_nxt == '0);
`else
    assign w_mul_done = w_last;
`endif

    // Sign fix-up of the magnitude results
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    assign w_prod_s = (r_signA ^ r_signB) ? (-r_prod) : r_prod;
    assign w_quo_s  = (r_signA ^ r_signB) ? (-r_quo) : r_quo;
    assign w_rem_s  = r_signA ? (-r_rem) : r_rem;

    // Sequencer FSM, datapath registers and HI/LO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_srcA    <= '0;
            r_signA   <= 1'b0;
            r_signB   <= 1'b0;
            r_div     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu.startE) begin
                        r_prod    <= '0;
                        r_mcand   <= {{WIDTH{1'b0}}, w_magA};
                        r_mplier  <= w_magB;
                        r_rem     <= '0;
                        r_quo     <= w_magA;
                        r_divisor <= w_magB;
                        r_srcA    <= mdu.srcAE;
                        r_signA   <= w_sa;
                        r_signB   <= w_sb;
                        r_div     <= mdu.opE[1];
                        r_count   <= '0;
                        r_state   <= mdu.opE[1] ? S_DIV : S_MUL;
                    end else begin
                        if (mdu.mthiE) r_hi <= mdu.srcAE;
                        if (mdu.mtloE) r_lo <= mdu.srcAE;
                    end
                end
                S_MUL: begin
                    r_prod   <= w_prod_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_nxt;
                    r_count  <= r_count + CW'(1);
                    if (w_mul_done) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_rem   <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
                    r_quo   <= {r_quo[WIDTH-2:0], w_ge};
                    r_count <= r_count + CW'(1);
                    if (w_last) r_state <= S_FIX;
                end
                default: begin
                    if (r_div) begin
                        if (r_divisor == '0) begin
                            r_lo <= '1;
                            r_hi <= r_srcA;
                        end else begin
                            r_lo <= w_quo_s;
                            r_hi <= w_rem_s;
                        end
                    end else begin
                        r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_s[WIDTH-1:0];
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mdu.hiOut     = r_hi;
    assign mdu.loOut     = r_lo;
    assign mdu.busy      = (r_state != S_IDLE);
    assign mdu.mduStallE = mdu.busy & (mdu.startE | mdu.mthiE | mdu.mtloE |
                                       mdu.mfhiE  | mdu.mfloE);
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq against a plain-arithmetic
// model of MIPS32 HI/LO semantics and the expected busy latency.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    mdu_seq_if #(.WIDTH(32)) bus();
    mdu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .mdu(bus));

    always #5 clk = ~clk;

    // MIPS HI/LO result from 64-bit arithmetic
    function automatic void ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
        longint pa, pb;
        logic [63:0] p, q, r;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        hi = '0; lo = '0;
        case (op)
            2'd0: begin p = pa * pb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else if (op == 2'd2) begin
                    q = pa / pb; r = pa % pb; lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Expected number of busy cycles after the start edge
    function automatic int exp_busy(input logic [1:0] op, input logic [31:0] b);
        int n;
        logic [31:0] mag;
        n = 33;
`ifdef MDU_EARLY_OUT_EN
        if (!op[1]) begin
            mag = (!op[0] && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
            n = n + 1;
        end
`endif
        mag = b;
        return n;
    endfunction

    task automatic clear_in();
        bus.startE = 1'b0; bus.opE = 2'd0; bus.srcAE = '0; bus.srcBE = '0;
        bus.mthiE = 1'b0; bus.mtloE = 1'b0; bus.mfhiE = 1'b0; bus.mfloE = 1'b0;
    endtask

    // Issue one op, then hold an MFLO in E until the engine returns to IDLE
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int nbusy, output int nstall,
                          output logic idle_stall, output logic moved);
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = bus.hiOut; l0 = bus.loOut;
        clear_in();
        bus.startE = 1'b1; bus.opE = op; bus.srcAE = a; bus.srcBE = b;
        @(negedge clk);
        clear_in();
        bus.mfloE = 1'b1;
        #1;
        nbusy = 0; nstall = 0; moved = 1'b0;
        while (bus.busy && nbusy < 100) begin
            nbusy++;
            if (bus.mduStallE) nstall++;
            if (bus.hiOut !== h0 || bus.loOut !== l0) moved = 1'b1;
            @(negedge clk);
        end
        idle_stall = bus.mduStallE;
        hi = bus.hiOut; lo = bus.loOut;
        bus.mfloE = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.mfhiE = 1'b1;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
        n_total++; if (bus.mduStallE !== 1'b0) $display("FAIL reset_stall got=%b want=0", bus.mduStallE); else n_pass++;
        n_total++; if (bus.hiOut !== 32'd0) $display("FAIL reset_hi got=%h want=0", bus.hiOut); else n_pass++;
        n_total++; if (bus.loOut !== 32'd0) $display("FAIL reset_lo got=%h want=0", bus.loOut); else n_pass++;
        bus.mfhiE = 1'b0;
        rst_n = 1'b1;
    endtask

    // Directed cases with full stall/latency observation, then random ones
    task automatic test_ops();
        logic [1:0]  ops [9]  = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1};
        logic [31:0] as  [9]  = '{32'd3, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100,
                                  32'h8000_0000, 32'h1234, 32'd5, 32'hFFFF_FFFF};
        logic [31:0] bs  [9]  = '{32'd5, 32'd3, 32'h8000_0000, 32'd2, 32'd7,
                                  32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] hi, lo, ehi, elo;
        int nb, ns, eb;
        logic istall, moved;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], hi, lo, nb, ns, istall, moved);
            ref_mdu(ops[i], as[i], bs[i], ehi, elo);
            eb = exp_busy(ops[i], bs[i]);
            n_total++; if (hi !== ehi) $display("FAIL dir%0d_hi got=%h want=%h", i, hi, ehi); else n_pass++;
            n_total++; if (lo !== elo) $display("FAIL dir%0d_lo got=%h want=%h", i, lo, elo); else n_pass++;
            n_total++; if (nb != eb) $display("FAIL dir%0d_busy got=%0d want=%0d", i, nb, eb); else n_pass++;
            n_total++; if (ns != eb) $display("FAIL dir%0d_stall got=%0d want=%0d", i, ns, eb); else n_pass++;
            n_total++; if (istall !== 1'b0) $display("FAIL dir%0d_idle_stall got=%b want=0", i, istall); else n_pass++;
            n_total++; if (moved !== 1'b0) $display("FAIL dir%0d_hilo_busy got=%b want=0", i, moved); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo, ehi, elo;
        int nb, ns, eb;
        logic istall, moved;
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            case (i % 4)
                0: b = 32'($urandom_range(0, 9));
                1: b = -32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            run_op(op, a, b, hi, lo, nb, ns, istall, moved);
            ref_mdu(op, a, b, ehi, elo);
            eb = exp_busy(op, b);
            n_total++; if (hi !== ehi) $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, hi, ehi); else n_pass++;
            n_total++; if (lo !== elo) $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, lo, elo); else n_pass++;
            n_total++; if (nb != eb) $display("FAIL rnd%0d_busy got=%0d want=%0d", i, nb, eb); else n_pass++;
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] ehi, elo;
        int ns;
        @(negedge clk);
        clear_in(); bus.mthiE = 1'b1; bus.srcAE = 32'hAAAA_0000;
        #1;
        n_total++; if (bus.mduStallE !== 1'b0) $display("FAIL mthi_stall got=%b want=0", bus.mduStallE); else n_pass++;
        @(negedge clk);
        clear_in(); bus.mtloE = 1'b1; bus.srcAE = 32'h0000_5555;
        #1;
        n_total++; if (bus.hiOut !== 32'hAAAA_0000) $display("FAIL mthi_hi got=%h want=aaaa0000", bus.hiOut); else n_pass++;
        n_total++; if (bus.mduStallE !== 1'b0) $display("FAIL mtlo_stall got=%b want=0", bus.mduStallE); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.loOut !== 32'h0000_5555) $display("FAIL mtlo_lo got=%h want=00005555", bus.loOut); else n_pass++;
        n_total++; if (bus.hiOut !== 32'hAAAA_0000) $display("FAIL mtlo_hi_kept got=%h want=aaaa0000", bus.hiOut); else n_pass++;
        clear_in(); bus.mthiE = 1'b1; bus.mtloE = 1'b1; bus.srcAE = 32'h1357_2468;
        @(negedge clk);
        clear_in();
        n_total++; if (bus.hiOut !== 32'h1357_2468 || bus.loOut !== 32'h1357_2468)
            $display("FAIL mthilo_both got=%h/%h want=13572468/13572468", bus.hiOut, bus.loOut); else n_pass++;
        // MTHI held behind a running MULTU: ignored while busy, applied after
        bus.startE = 1'b1; bus.opE = 2'd1; bus.srcAE = 32'd3; bus.srcBE = 32'd5;
        @(negedge clk);
        clear_in(); bus.mthiE = 1'b1; bus.srcAE = 32'hDEAD_0001;
        #1;
        ns = 0;
        while (bus.busy && ns < 100) begin
            if (bus.mduStallE && bus.hiOut === 32'h1357_2468) ns++;
            @(negedge clk);
        end
        n_total++; if (ns != exp_busy(2'd1, 32'd5)) $display("FAIL mthi_held_stall got=%0d want=%0d", ns, exp_busy(2'd1, 32'd5)); else n_pass++;
        ref_mdu(2'd1, 32'd3, 32'd5, ehi, elo);
        n_total++; if (bus.hiOut !== ehi || bus.loOut !== elo) $display("FAIL mthi_held_result got=%h/%h want=%h/%h", bus.hiOut, bus.loOut, ehi, elo); else n_pass++;
        @(negedge clk);
        clear_in();
        n_total++; if (bus.hiOut !== 32'hDEAD_0001 || bus.loOut !== elo) $display("FAIL mthi_after got=%h/%h want=dead0001/%h", bus.hiOut, bus.loOut, elo); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, ehi, elo;
        int ns, nb, eb;
        a1 = 32'd1000; b1 = 32'hFFFF_FFF9;
        a2 = $urandom;  b2 = $urandom;
        @(negedge clk);
        clear_in(); bus.startE = 1'b1; bus.opE = 2'd2; bus.srcAE = a1; bus.srcBE = b1;
        @(negedge clk);
        clear_in();
        repeat (9) @(negedge clk);
        bus.startE = 1'b1; bus.opE = 2'd0; bus.srcAE = a2; bus.srcBE = b2;
        @(negedge clk);
        ns = 0;
        while (bus.busy && ns < 100) begin
            if (bus.mduStallE) ns++;
            @(negedge clk);
        end
        n_total++; if (ns != 23) $display("FAIL b2b_stall got=%0d want=23", ns); else n_pass++;
        n_total++; if (bus.mduStallE !== 1'b0) $display("FAIL b2b_idle_stall got=%b want=0", bus.mduStallE); else n_pass++;
        ref_mdu(2'd2, a1, b1, ehi, elo);
        n_total++; if (bus.hiOut !== ehi || bus.loOut !== elo) $display("FAIL b2b_first got=%h/%h want=%h/%h", bus.hiOut, bus.loOut, ehi, elo); else n_pass++;
        @(negedge clk);
        clear_in(); bus.mfloE = 1'b1;
        #1;
        nb = 0;
        while (bus.busy && nb < 100) begin nb++; @(negedge clk); end
        bus.mfloE = 1'b0;
        eb = exp_busy(2'd0, b2);
        n_total++; if (nb != eb) $display("FAIL b2b_second_busy got=%0d want=%0d", nb, eb); else n_pass++;
        ref_mdu(2'd0, a2, b2, ehi, elo);
        n_total++; if (bus.hiOut !== ehi || bus.loOut !== elo) $display("FAIL b2b_second got=%h/%h want=%h/%h", bus.hiOut, bus.loOut, ehi, elo); else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [31:0] hi, lo;
        int nb, ns;
        logic istall, moved;
        @(negedge clk);
        clear_in(); bus.startE = 1'b1; bus.opE = 2'd2; bus.srcAE = 32'hFFFF_0000; bus.srcBE = 32'd3;
        @(negedge clk);
        clear_in();
        repeat (11) @(negedge clk);
        n_total++; if (bus.busy !== 1'b1) $display("FAIL midop_busy_before got=%b want=1", bus.busy); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mfloE = 1'b1;
        #1;
        n_total++; if (bus.busy !== 1'b0 || bus.mduStallE !== 1'b0) $display("FAIL midop_busy got=%b/%b want=0/0", bus.busy, bus.mduStallE); else n_pass++;
        n_total++; if (bus.hiOut !== 32'd0 || bus.loOut !== 32'd0) $display("FAIL midop_hilo got=%h/%h want=0/0", bus.hiOut, bus.loOut); else n_pass++;
        bus.mfloE = 1'b0;
        run_op(2'd3, 32'd9, 32'd3, hi, lo, nb, ns, istall, moved);
        n_total++; if (lo !== 32'd3 || hi !== 32'd0) $display("FAIL midop_divu got=%h/%h want=0/3", hi, lo); else n_pass++;
        n_total++; if (nb != 33) $display("FAIL midop_divu_busy got=%0d want=33", nb); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_random();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Iterative multiply/divide sequencer for the 5-stage MIPS32 pipeline. It owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over multiple cycles as a shift-add or restoring-divide engine. It stalls the pipeline while any instruction that touches HI/LO sits in E during an operation.
- Produces mduStallE; top-level ORs it into stallF/stallD and holds the E stage.
- MFHI/MFLO read hiOut/loOut in E.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
startE  in  1  valid mult/div instruction in E (already gated by flushE)
opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srcAE  in  WIDTH  rs operand (multiplicand / dividend)
srcBE  in  WIDTH  rt operand (multiplier / divisor)
mthiE  in  1  MTHI in E; write srcAE to HI
mtloE  in  1  MTLO in E; write srcAE to LO
mfhiE  in  1  MFHI in E
mfloE  in  1  MFLO in E
hiOut  out  WIDTH  HI register
loOut  out  WIDTH  LO register
busy  out  1  engine active (state != IDLE)
mduStallE  out  1  hold F/D/E this cycle

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-low (rst_n); no asynchronous reset path.
- Reset (rst_n=0 at an edge): state=IDLE, count=0, internal accumulators=0, hiOut=0, loOut=0. busy=0 and mduStallE=0 follow combinationally. Reset mid-operation abandons the operation; HI/LO still read 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start:
  - Edge E0 with startE=1 captures |srcAE| and |srcBE| for signed ops (raw values for unsigned).
  - Records signA, signB, opE, and the original srcAE; count=0.
  - Goes to MUL (op 0x) or DIV (op 1x).
- MUL: one shift-add step per edge, consuming the multiplier LSB. The 2*WIDTH product accumulates.
- DIV: one restoring step per edge; the remainder shifts left, subtracts the divisor, and restores on a negative result.
- Iteration edges are E1..EWIDTH. count increments each edge; at count==WIDTH-1 the state goes to FIX.
- FIX, result and sign rules (edge EWIDTH+1 writes HI/LO, returns to IDLE):
  - MULT: product negated if signA^signB. HI=upper, LO=lower.
  - MULTU: no sign fix.
  - DIV: quotient negated if signA^signB, remainder negated if signA. LO=quotient, HI=remainder.
  - 0x80000000 / -1: LO=0x80000000, HI=0.
  - DIVU: no sign fix.
  - Divisor==0 (DIV or DIVU): LO=0xFFFFFFFF, HI=original srcAE. Full latency still applies.
- Latency: busy is high for WIDTH+1 cycles (33) after E0. Result is visible on hiOut/loOut from the cycle after E33.
- MTHI/MTLO in IDLE: HI (or LO) = srcAE at that edge, one cycle, no stall. Both asserted writes both.
- mduStallE = busy & (startE | mthiE | mtloE | mfhiE | mfloE), combinational. While stalled the E inputs are held stable and ignored.
- In FIX, mduStallE is still asserted; the held instruction proceeds in the first IDLE cycle. MFHI/MFLO then sees the new value.
- startE in IDLE with mthiE/mtloE also set is illegal (decoder guarantees exclusivity); no defined priority is required.
- HI/LO are never modified while busy except at the FIX edge.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: in MUL, if the remaining multiplier register is zero after an iteration edge's shift, that edge moves directly to FIX. This applies to MULT and MULTU; the magnitude is used for signed. DIV timing is unchanged.
- Undefined: MUL always runs WIDTH iterations; latency is a fixed 33 cycles.

Test Plan:
1. MULTU srcA=3, srcB=5, then MFLO held in E -> stall asserted 33 cycles (no EN); LO=15, HI=0; stall drops in the first IDLE cycle. With MDU_EARLY_OUT_EN: FIX entered at E3, HI/LO written at E4, busy 4 cycles.
2. MULT 0xFFFFFFFE * 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
3. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234 after 33 cycles; DIV 5 / 0 -> LO=0xFFFFFFFF, HI=5.
5. MTHI 0xAAAA0000 and MTLO 0x5555 in IDLE -> next cycle HI/LO hold those values, no stall. A second MULT issued at E10 of a running op -> mduStallE=1 until IDLE; it then starts and produces its own result.
6. rst_n=0 for one edge at E12 of a DIV -> state IDLE, busy=0, HI=LO=0 next cycle. A following DIVU 9/3 -> LO=3, HI=0.
